adbg_jsp_apb_biu: RTL
=====================

# adbg_jsp_apb_biu

Bus-side endpoint of the JTAG Serial Port (JSP): presents a 16550-subset UART register set on an APB slave so target software can exchange bytes with the debug host. It buffers host→CPU bytes in an RX FIFO and CPU→host bytes in a TX FIFO. Both FIFOs are exchanged with the JSP debug-module side over valid/ready byte handshakes. Occupancy counts are exported for packing into the 64-bit JSP data register.

## Interface
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of count outputs.
- PCLK  in  1  clock; all logic is single-clock.
- PRESETn  in  1  reset; asynchronous assert, active-low.
- PSEL, PENABLE, PWRITE  in  1  APB control.
- PADDR  in  3  byte register address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data; valid in the access phase.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  tied 0.
- dbg_wr_data  in  8  host→CPU byte.
- dbg_wr_valid  in  1  byte offered.
- dbg_wr_ready  out  1  RX FIFO not full.
- dbg_rd_data  out  8  CPU→host byte; head of TX FIFO.
- dbg_rd_valid  out  1  TX FIFO not empty.
- dbg_rd_ready  in  1  host consumes byte.
- dbg_rx_free  out  CNT_W  free RX entries.
- dbg_tx_count  out  CNT_W  occupied TX entries.
- int_o  out  1  interrupt, active-high level.

## Operation
- Access = PSEL & PENABLE. Writes commit at the PCLK edge ending the access. Reads drive PRDATA combinationally during the access and 0x00 otherwise.
- Register map:
  - 0: read RBR = RX head (0x00 if empty), pops on read. Write THR pushes to TX; dropped if TX is full.
  - 1: IER. Bit0 ERBFI, bit1 ETBEI; other bits read 0.
  - 2: read IIR. Write FCR: bit1 clears RX, bit2 clears TX, other bits ignored.
  - 3: LCR, 8-bit storage only, reset 0x03.
  - 5: LSR read-only. Bit0 DR = RX not empty; bit5 THRE = TX empty; bit6 TEMT = TX empty. Other bits 0.
  - 7: SCR scratch, reset 0x00.
  - 4 and 6: read 0x00, writes ignored.
- IIR priority: 0xC4 when ERBFI & DR; else 0xC2 when ETBEI & thre_pend; else 0xC1.
- thre_pend:
  - Set on the edge at which TX becomes empty, or when ETBEI is written 0→1 while TX is empty.
  - Cleared by a THR write, or by an IIR read returning 0xC2.
- int_o = (ERBFI & DR) | (ETBEI & thre_pend), registered.
- Debug handshakes: a byte transfers on an edge where valid & ready. RX push and RBR pop may coincide; so may TX push and dbg pop.
- dbg_wr_ready is derived from pre-edge state only. When RX is full, a same-cycle RBR pop does not admit a push.
- A FIFO clear in the same cycle as a push or pop leaves that FIFO empty; clear wins.
- Reading or popping an empty FIFO has no effect, and pointers do not move.
- Pointers wrap modulo FIFO_DEPTH. Counts saturate naturally in 0..FIFO_DEPTH.

## Timing
- Reset values:
  - PRDATA 0x00, int_o 0.
  - dbg_wr_ready 1, dbg_rd_valid 0, dbg_rd_data 0x00.
  - dbg_rx_free FIFO_DEPTH, dbg_tx_count 0.
  - IER 0, LCR 0x03, SCR 0, thre_pend 0.
- THR write at edge N: dbg_rd_valid=1 and LSR.THRE=0 after edge N.
- dbg push at edge N: DR=1 after edge N. int_o=1 after edge N+1 if ERBFI=1.
- FIFO storage uses first-word-fall-through; no read latency.
- Reset asserted mid-transfer discards all FIFO contents and pending interrupts immediately.

## Configuration
- ADBG_JSP_INTERRUPT_EN defined: IER, IIR, thre_pend and int_o behave as above.
- Not defined:
  - IER reads 0x00 and writes are ignored.
  - IIR always reads 0xC1; int_o is tied 0.
  - No thre_pend or interrupt registers are synthesised.

## Structure
- adbg_jsp_pkg gains:
  - Register address constants: JSP_ADR_RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, LSR=5, SCR=7.
  - IIR codes JSP_IIR_RDA=8'hC4, JSP_IIR_THRE=8'hC2, JSP_IIR_NONE=8'hC1.
  - LSR bit indices.
- Sub-module adbg_jsp_fifo, instantiated twice: synchronous FWFT FIFO with push, pop, clear, data, empty, full and count. The top holds the register decode and interrupt logic.

## Test plan
- Reset → LSR=0x60, IIR=0xC1, dbg_wr_ready=1, dbg_rx_free=8, dbg_tx_count=0, int_o=0.
- Write THR 0x41, 0x42 → dbg_tx_count=2, dbg_rd_data=0x41. Pop once → 0x42. Pop again → dbg_rd_valid=0, LSR bit5=1.
- Push 8 host bytes 0x00..0x07 → dbg_wr_ready=0; a 9th offer is refused. Read RBR eight times → 0x00..0x07, then DR=0.
- IER=0x01, push 0x55 → int_o=1, IIR=0xC4. Read RBR → 0x55, then int_o=0, IIR=0xC1.
- IER=0x02 with TX empty → IIR=0xC2, int_o=1. Read IIR → next read 0xC1, int_o=0. Write THR and drain via dbg → IIR=0xC2 again.
- RX full plus a same-cycle FCR=0x02 and dbg push → RX empty, dbg_rx_free=8, DR=0. Repeat with the macro undefined → IIR reads 0xC1 and int_o stays 0 throughout.

Source files
------------

// File: rtl/adbg_jsp_pkg.sv
// Shared constants for the JTAG Serial Port APB endpoint: register map, IIR codes, LSR/FCR bits.
// Interrupt support is compiled in with ADBG_JSP_INTERRUPT_EN.
package adbg_jsp_pkg;

   localparam logic [2:0] JSP_ADR_RBR_THR = 3'd0;
   localparam logic [2:0] JSP_ADR_IER     = 3'd1;
   localparam logic [2:0] JSP_ADR_IIR_FCR = 3'd2;
   localparam logic [2:0] JSP_ADR_LCR     = 3'd3;
   localparam logic [2:0] JSP_ADR_LSR     = 3'd5;
   localparam logic [2:0] JSP_ADR_SCR     = 3'd7;

   localparam logic [7:0] JSP_IIR_RDA  = 8'hC4;
   localparam logic [7:0] JSP_IIR_THRE = 8'hC2;
   localparam logic [7:0] JSP_IIR_NONE = 8'hC1;

   localparam int unsigned JSP_LSR_DR   = 0;
   localparam int unsigned JSP_LSR_THRE = 5;
   localparam int unsigned JSP_LSR_TEMT = 6;

   localparam int unsigned JSP_FCR_CLR_RX = 1;
   localparam int unsigned JSP_FCR_CLR_TX = 2;

   localparam logic [7:0] JSP_LCR_RESET = 8'h03;

   function automatic logic [7:0] jsp_lsr(input logic rx_empty, input logic tx_empty);
      logic [7:0] v;
      v               = '0;
      v[JSP_LSR_DR]   = ~rx_empty;
      v[JSP_LSR_THRE] = tx_empty;
      v[JSP_LSR_TEMT] = tx_empty;
      return v;
   endfunction

endpackage

// File: rtl/adbg_jsp_fifo.sv
// Single-clock first-word-fall-through byte FIFO with synchronous clear.
// Push when full and pop when empty are ignored; clear overrides both.
module adbg_jsp_fifo
   import adbg_jsp_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clr_i,
   input  logic [7:0]       data_i,
   output logic [7:0]       data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic        do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count_o = CNT_W'(wptr_q - rptr_q);
   assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_ONE;
         if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/adbg_jsp_apb_biu.sv
// APB-side JSP endpoint: 16550-subset register file over RX/TX byte FIFOs.
// Define ADBG_JSP_INTERRUPT_EN to build IER, IIR priority, THRE tracking and int_o.
module adbg_jsp_apb_biu
   import adbg_jsp_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [2:0]       PADDR,
   input  logic [7:0]       PWDATA,
   output logic [7:0]       PRDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   input  logic [7:0]       dbg_wr_data,
   input  logic             dbg_wr_valid,
   output logic             dbg_wr_ready,
   output logic [7:0]       dbg_rd_data,
   output logic             dbg_rd_valid,
   input  logic             dbg_rd_ready,
   output logic [CNT_W-1:0] dbg_rx_free,
   output logic [CNT_W-1:0] dbg_tx_count,
   output logic             int_o
);

   logic             wr_acc, rd_acc, fcr_wr;
   logic             rx_push, rx_pop, rx_clr, rx_empty, rx_full;
   logic             tx_push, tx_pop, tx_clr, tx_empty, tx_full;
   logic [7:0]       rx_data;
   logic [CNT_W-1:0] rx_count, tx_count;
   logic [7:0]       lcr_q, lcr_d, scr_q, scr_d;
   logic [7:0]       ier_rd, iir;

   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;

   assign wr_acc = PSEL & PENABLE & PWRITE;
   assign rd_acc = PSEL & PENABLE & ~PWRITE;
   assign fcr_wr = wr_acc && (PADDR == JSP_ADR_IIR_FCR);

   assign rx_push = dbg_wr_valid & ~rx_full;
   assign rx_pop  = rd_acc && (PADDR == JSP_ADR_RBR_THR);
   assign rx_clr  = fcr_wr & PWDATA[JSP_FCR_CLR_RX];
   assign tx_push = wr_acc && (PADDR == JSP_ADR_RBR_THR);
   assign tx_pop  = dbg_rd_ready & ~tx_empty;
   assign tx_clr  = fcr_wr & PWDATA[JSP_FCR_CLR_TX];

   adbg_jsp_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
      .clk_i(PCLK), .rst_ni(PRESETn), .push_i(rx_push), .pop_i(rx_pop), .clr_i(rx_clr),
      .data_i(dbg_wr_data), .data_o(rx_data), .empty_o(rx_empty), .full_o(rx_full),
      .count_o(rx_count)
   );

   adbg_jsp_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
      .clk_i(PCLK), .rst_ni(PRESETn), .push_i(tx_push), .pop_i(tx_pop), .clr_i(tx_clr),
      .data_i(PWDATA), .data_o(dbg_rd_data), .empty_o(tx_empty), .full_o(tx_full),
      .count_o(tx_count)
   );

   assign dbg_wr_ready = ~rx_full;
   assign dbg_rd_valid = ~tx_empty;
   assign dbg_rx_free  = CNT_W'(FIFO_DEPTH) - rx_count;
   assign dbg_tx_count = tx_count;

`ifdef ADBG_JSP_INTERRUPT_EN
   logic [1:0] ier_q, ier_d;
   logic       thre_pend_q, thre_pend_d, int_q, int_d;
   logic       tx_empty_nxt, rda_cond, thre_cond;

   assign rda_cond  = ier_q[0] & ~rx_empty;
   assign thre_cond = ier_q[1] & thre_pend_q;
   assign iir       = rda_cond ? JSP_IIR_RDA : (thre_cond ? JSP_IIR_THRE : JSP_IIR_NONE);
   assign ier_rd    = {6'b0, ier_q};
   assign int_o     = int_q;

   // TX goes empty this edge on a clear, or when its last entry leaves with no refill.
   assign tx_empty_nxt = tx_clr | ((tx_count == CNT_W'(1)) & tx_pop & ~tx_push);

   always_comb begin
      ier_d       = ier_q;
      thre_pend_d = thre_pend_q;
      int_d       = rda_cond | thre_cond;
      if (tx_push) thre_pend_d = 1'b0;
      if (rx_pop_iir_c2()) thre_pend_d = 1'b0;
      if (~tx_empty & tx_empty_nxt) thre_pend_d = 1'b1;
      if (wr_acc && (PADDR == JSP_ADR_IER)) begin
         ier_d = PWDATA[1:0];
         if (PWDATA[1] & ~ier_q[1] & tx_empty) thre_pend_d = 1'b1;
      end
   end

   function automatic logic rx_pop_iir_c2();
      return rd_acc && (PADDR == JSP_ADR_IIR_FCR) && (iir == JSP_IIR_THRE);
   endfunction

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ier_q       <= '0;
         thre_pend_q <= 1'b0;
         int_q       <= 1'b0;
      end else begin
         ier_q       <= ier_d;
         thre_pend_q <= thre_pend_d;
         int_q       <= int_d;
      end
   end
`else
   assign ier_rd = '0;
   assign iir    = JSP_IIR_NONE;
   assign int_o  = 1'b0;
`endif

   always_comb begin
      lcr_d = lcr_q;
      scr_d = scr_q;
      if (wr_acc && (PADDR == JSP_ADR_LCR)) lcr_d = PWDATA;
      if (wr_acc && (PADDR == JSP_ADR_SCR)) scr_d = PWDATA;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         lcr_q <= JSP_LCR_RESET;
         scr_q <= '0;
      end else begin
         lcr_q <= lcr_d;
         scr_q <= scr_d;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (rd_acc) begin
         case (PADDR)
            JSP_ADR_RBR_THR: PRDATA = rx_data;
            JSP_ADR_IER:     PRDATA = ier_rd;
            JSP_ADR_IIR_FCR: PRDATA = iir;
            JSP_ADR_LCR:     PRDATA = lcr_q;
            JSP_ADR_LSR:     PRDATA = jsp_lsr(rx_empty, tx_empty);
            JSP_ADR_SCR:     PRDATA = scr_q;
            default:         PRDATA = '0;
         endcase
      end
   end

endmodule
